// File: rtl/tick_sched_pkg.sv
// Shared types, limits and the round-robin helper for the tick scheduler.
package tick_sched_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int N_CH_MAX = 8;
   localparam int IDX_W    = 3;

   // First requesting channel strictly after last, wrapping within n channels.
   function automatic logic [IDX_W-1:0] rr_next(input logic [N_CH_MAX-1:0] req,
                                                input logic [IDX_W-1:0]    last,
                                                input int                  n);
      logic [IDX_W-1:0] pick;
      logic [IDX_W-1:0] idx;
      pick = last;
      for (int k = N_CH_MAX; k >= 1; k--) begin
         idx = IDX_W'((int'(last) + k) % n);
         if (k <= n && req[idx]) pick = idx;
      end
      return pick;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running base tick: one pulse every BASE_CYCLES+1 clocks, frozen by pause.
module tick_gen #(
   parameter int BASE_CYCLES = 650000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pause,
   output logic base_tick
);

   localparam int CNT_W = (BASE_CYCLES < 1) ? 1 : $clog2(BASE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BASE_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;

   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (!pause) begin
         if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   // A tick registered just before pause rises is suppressed while paused.
   assign base_tick = tick_q & ~pause;

endmodule

// File: rtl/tick_scheduler.sv
// Divides the base tick per channel and grants one consumer at a time via go/done.
module tick_scheduler
   import tick_sched_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int BASE_CYCLES = 650000,
   parameter int PERIOD_W    = 8,
   parameter int TIMEOUT     = 4096
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_CH-1:0]          enable,
   input  logic [N_CH*PERIOD_W-1:0] period,
   input  logic                     pause,
   input  logic [N_CH-1:0]          done,
   input  logic                     clr_flags,
   output logic [N_CH-1:0]          go,
   output logic                     base_tick,
   output logic                     busy,
   output logic [N_CH-1:0]          overrun,
   output logic                     timeout
);

   localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   arb_state_e          state_q, state_d;
   logic [PERIOD_W-1:0] cnt_q [N_CH];
   logic [PERIOD_W-1:0] cnt_d [N_CH];
   logic [N_CH-1:0]     pend_q, pend_d, go_q, go_d, ovr_q, ovr_d;
   logic [IDX_W-1:0]    sel_q, sel_d, last_q, last_d, pick;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic                to_q, to_d, to_set;
   logic [N_CH-1:0]     fire, off, req, ovr_set, grant;
   logic [N_CH_MAX-1:0] done_ext;
   logic [PERIOD_W-1:0] p;

   tick_gen #(.BASE_CYCLES(BASE_CYCLES)) u_tick_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .pause     (pause),
      .base_tick (base_tick)
   );

   assign done_ext = N_CH_MAX'(done);

   always_comb begin
      fire = '0;
      off  = '0;
      p    = '0;
      for (int i = 0; i < N_CH; i++) begin
         cnt_d[i] = cnt_q[i];
         p        = period[i*PERIOD_W +: PERIOD_W];
         off[i]   = !enable[i] || (p == '0);
         if (off[i]) begin
            cnt_d[i] = '0;
         end else if (base_tick) begin
            // >= keeps a counter from running away if the period shrinks mid-count
            if (cnt_q[i] >= p - 1'b1) begin
               cnt_d[i] = '0;
               fire[i]  = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
      ovr_set = fire & (pend_q | go_q);
      req     = (pend_q | (fire & ~go_q)) & ~off;
   end

   always_comb begin
      state_d = state_q;
      go_d    = go_q;
      sel_d   = sel_q;
      last_d  = last_q;
      tmr_d   = tmr_q;
      grant   = '0;
      to_set  = 1'b0;
      pick    = rr_next(N_CH_MAX'(req), last_q, N_CH);
      case (state_q)
         IDLE: begin
            // Fresh fires are visible here so go rises the cycle after base_tick.
            if (|req) begin
               grant   = N_CH'(1) << pick;
               go_d    = grant;
               sel_d   = pick;
               tmr_d   = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (done_ext[sel_q]) begin
               go_d    = '0;
               last_d  = sel_q;
               state_d = IDLE;
            end else if (tmr_q == TMR_LAST) begin
               go_d    = '0;
               last_d  = sel_q;
               to_set  = 1'b1;
               state_d = IDLE;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pend_d = req & ~grant;
      ovr_d  = (ovr_q & ~{N_CH{clr_flags}}) | ovr_set;
      to_d   = (to_q & ~clr_flags) | to_set;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pend_q  <= '0;
         go_q    <= '0;
         ovr_q   <= '0;
         to_q    <= 1'b0;
         sel_q   <= '0;
         last_q  <= IDX_W'(N_CH - 1);
         tmr_q   <= '0;
         for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         go_q    <= go_d;
         ovr_q   <= ovr_d;
         to_q    <= to_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         tmr_q   <= tmr_d;
         for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign go      = go_q;
   assign busy    = (state_q == GRANT);
   assign overrun = ovr_q;
   assign timeout = to_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed and randomized bench for tick_scheduler against a behavioural model.
module tb_tick_scheduler;

   localparam int N_CH = 4;
   localparam int BC   = 3;
   localparam int PW   = 8;
   localparam int TO   = 16;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 pause = 1'b0;
   logic                 clr_flags = 1'b0;
   logic [N_CH-1:0]      enable = '0;
   logic [N_CH-1:0]      done = '0;
   logic [N_CH*PW-1:0]   period = '0;
   logic [N_CH-1:0]      go, overrun;
   logic                 base_tick, busy, timeout;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int dly = 999;
   bit rnd_done = 1'b0;

   // Behavioural reference state
   int              m_active, m_sel, m_last, m_age;
   int              m_seen [N_CH];
   bit              m_tick, m_busy, m_to;
   bit [N_CH-1:0]   m_pend, m_ovr;

   // Directed-test scratch
   int              len, last_tick, prev_idx, idx, ticks, busy_seen, n;
   bit              found, prev_g;
   logic [N_CH-1:0] prev_v, first;
   logic [N_CH*PW-1:0] rper;
   int              rises [$];

   tick_scheduler #(
      .N_CH(N_CH), .BASE_CYCLES(BC), .PERIOD_W(PW), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .period(period), .pause(pause),
      .done(done), .clr_flags(clr_flags), .go(go), .base_tick(base_tick),
      .busy(busy), .overrun(overrun), .timeout(timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, observed cycle %0d required < 40000", cyc);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int per(input int i);
      return int'(period[i*PW +: PW]);
   endfunction

   function automatic logic [N_CH-1:0] m_go();
      logic [N_CH-1:0] g;
      g = '0;
      if (m_busy) g[m_sel] = 1'b1;
      return g;
   endfunction

   function automatic int m_pick(input bit [N_CH-1:0] r);
      for (int k = 1; k <= N_CH; k++)
         if (r[(m_last + k) % N_CH]) return (m_last + k) % N_CH;
      return 0;
   endfunction

   task automatic model_reset();
      m_active = 0; m_tick = 0; m_pend = '0; m_ovr = '0; m_to = 0;
      m_busy = 0; m_sel = 0; m_last = N_CH - 1; m_age = 0;
      for (int i = 0; i < N_CH; i++) m_seen[i] = 0;
   endtask

   // One active clock edge of the specified behaviour.
   task automatic model_edge();
      bit tick_now, to_set;
      bit [N_CH-1:0] fire, off, gonow, req, set_ovr;
      int c;
      tick_now = m_tick && !pause;
      gonow = m_go();
      fire = '0; off = '0; to_set = 0;
      for (int i = 0; i < N_CH; i++) begin
         if (!enable[i] || per(i) == 0) begin
            off[i] = 1; m_seen[i] = 0;
         end else if (tick_now) begin
            m_seen[i]++;
            fire[i] = (m_seen[i] % per(i) == 0);
         end
      end
      set_ovr = fire & (m_pend | gonow);
      req = (m_pend | (fire & ~gonow)) & ~off;
      m_pend = req;
      if (!m_busy) begin
         if (req != 0) begin
            c = m_pick(req);
            m_pend[c] = 0; m_busy = 1; m_sel = c; m_age = 0;
         end
      end else if (done[m_sel]) begin
         m_busy = 0; m_last = m_sel;
      end else if (m_age == TO - 1) begin
         m_busy = 0; m_last = m_sel; to_set = 1;
      end else begin
         m_age++;
      end
      m_ovr = (clr_flags ? '0 : m_ovr) | set_ovr;
      m_to  = (clr_flags ? 1'b0 : m_to) | to_set;
      if (!pause) begin
         m_active++;
         m_tick = (m_active % (BC + 1) == 0);
      end else begin
         m_tick = 0;
      end
   endtask

   task automatic drive_done();
      if (rnd_done) done = N_CH'($urandom);
      else begin
         done = '0;
         if (m_busy && m_age >= dly) done[m_sel] = 1'b1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n) model_edge();
      @(negedge clk);
      cyc++;
      chk("go", go, m_go());
      chk("busy", busy, m_busy);
      chk("base_tick", base_tick, m_tick && !pause);
      chk("overrun", overrun, m_ovr);
      chk("timeout", timeout, m_to);
      drive_done();
   endtask

   task automatic configure(input logic [N_CH-1:0] en, input logic [N_CH*PW-1:0] per_v);
      enable = '0;
      period = per_v;
      step();
      enable = en;
   endtask

   initial begin
      // Reset state and base tick cadence
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_go", go, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tick", base_tick, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_to", timeout, 0);
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("tick_cadence", base_tick, (k % 4 == 0));
      end

      // Single channel, period 2, done one cycle after go
      configure(4'b0001, {8'd0, 8'd0, 8'd0, 8'd2});
      dly = 1; len = 0; last_tick = -100; prev_g = 0;
      for (int k = 0; k < 70; k++) begin
         step();
         if (go[0] && !prev_g) begin
            rises.push_back(cyc);
            chk("sc_after_tick", cyc - last_tick, 1);
         end
         if (go[0]) len++;
         else if (prev_g) begin
            chk("sc_len", len, 2);
            len = 0;
         end
         if (base_tick) last_tick = cyc;
         prev_g = go[0];
      end
      chk("sc_count", rises.size() >= 4, 1);
      for (int k = 1; k < rises.size(); k++) chk("sc_spacing", rises[k] - rises[k-1], 8);

      // Round robin, all periods 1, immediate done
      configure(4'b1111, {8'd1, 8'd1, 8'd1, 8'd1});
      dly = 0; prev_idx = -1; prev_v = '0;
      for (int k = 0; k < 60; k++) begin
         step();
         chk("rr_onehot", $countones(go) <= 1, 1);
         if (go != 0 && prev_v == 0) begin
            idx = 0;
            for (int i = 0; i < N_CH; i++) if (go[i]) idx = i;
            if (prev_idx >= 0) chk("rr_order", idx, (prev_idx + 1) % N_CH);
            prev_idx = idx;
         end
         prev_v = go;
      end
      chk("rr_ovr3", overrun[3], 1);

      // Reset in the middle of a grant
      found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
         step();
         if (go[2]) found = 1;
      end
      chk("rm_saw_go2", found, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("rm_go", go, 0);
      chk("rm_busy", busy, 0);
      model_reset();
      done = '0;
      @(negedge clk);
      rst_n = 1'b1;
      found = 0; first = '0;
      for (int k = 0; k < 20 && !found; k++) begin
         step();
         if (go != 0) begin found = 1; first = go; end
      end
      chk("rm_found", found, 1);
      chk("rm_first", first, 4'b0001);

      // Overrun, timeout, clear, and set winning over clear
      dly = 0; enable = '0; clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      chk("ot_clr_ovr", overrun, 0);
      chk("ot_clr_to", timeout, 0);
      period = {8'd0, 8'd0, 8'd1, 8'd0}; enable = 4'b0010; dly = 999;
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         step();
         if (go[1]) found = 1;
      end
      chk("ot_go1", found, 1);
      len = 1;
      for (int k = 0; k < 40 && go[1]; k++) begin
         step();
         if (go[1]) len++;
      end
      chk("ot_len", len, TO);
      chk("ot_ovr1", overrun[1], 1);
      chk("ot_to", timeout, 1);
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      chk("ot_clr2_ovr", overrun, 0);
      chk("ot_clr2_to", timeout, 0);
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         step();
         if (base_tick && go[1]) found = 1;
      end
      chk("ot_co_found", found, 1);
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      chk("ot_coincide", overrun[1], 1);
      dly = 0;
      step();
      step();

      // Pause freezes ticks but leaves an open grant alone
      configure(4'b0001, {8'd0, 8'd0, 8'd0, 8'd1});
      dly = 999; found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         step();
         if (go[0]) found = 1;
      end
      chk("pz_go0", found, 1);
      pause = 1'b1; ticks = 0; busy_seen = 0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("pz_hold", go[0], 1);
         if (base_tick) ticks++;
      end
      dly = 0; done = 4'b0001;
      for (int k = 0; k < 17; k++) begin
         step();
         if (base_tick) ticks++;
         if (busy) busy_seen++;
      end
      chk("pz_no_tick", ticks, 0);
      chk("pz_no_grant", busy_seen, 0);
      pause = 1'b0;

      // Zero period with enable high never fires
      configure(4'b0001, '0);
      busy_seen = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (go != 0) busy_seen++;
      end
      chk("p0_never", busy_seen, 0);

      // Randomized traffic against the model
      rnd_done = 1'b1;
      for (int r = 0; r < 25; r++) begin
         for (int i = 0; i < N_CH; i++) rper[i*PW +: PW] = PW'($urandom_range(3, 0));
         configure(N_CH'($urandom), rper);
         n = $urandom_range(30, 10);
         for (int k = 0; k < n; k++) begin
            clr_flags = ($urandom_range(7, 0) == 0);
            if ($urandom_range(5, 0) == 0) pause = ~pause;
            step();
         end
         clr_flags = 1'b0;
         pause = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Shares one slow game tick among up to N_CH periodic consumers (alien march, player bullet, alien bullets, animation). An internal tick generator produces the base tick. Each channel divides that tick by its own runtime period. A round-robin arbiter grants exactly one channel at a time through a go/done handshake, so consumers that share a write port never collide. It sits between the system clock and the game-logic update blocks.

## Interface
- N_CH, 4: number of consumer channels (2..8).
- BASE_CYCLES, 650000: the base tick fires every BASE_CYCLES+1 clocks.
- PERIOD_W, 8: width of each channel period field.
- TIMEOUT, 4096: maximum number of cycles a grant may stay open without done.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  N_CH  per-channel enable.
- period  in  N_CH*PERIOD_W  packed per-channel period, in base ticks. Channel i uses bits [i*PERIOD_W +: PERIOD_W].
- pause  in  1  freezes the tick generator and all channel counters.
- done  in  N_CH  consumer completion strobe.
- clr_flags  in  1  one-cycle pulse that clears overrun and timeout.
- go  out  N_CH  one-hot grant, held until done or timeout.
- base_tick  out  1  one-cycle base tick pulse.
- busy  out  1  high while a grant is open.
- overrun  out  N_CH  sticky per-channel flag: the channel fired while a request was already outstanding.
- timeout  out  1  sticky flag: a grant was aborted by the timeout.

## Operation
- **Tick generator:** counter runs 0..BASE_CYCLES. base_tick is registered high in the cycle after the counter reaches BASE_CYCLES, and the counter wraps to 0. While pause=1 the counter holds and base_tick is 0.
- **Channel i, period P:**
  - P=0 or enable[i]=0: the counter is held at 0, pending[i] is cleared and the channel never fires.
  - Otherwise, on each base_tick the counter increments. When it reaches P-1 the channel fires and the counter returns to 0. So P=1 fires on every base tick.
  - A fire sets pending[i].
  - If pending[i] is already set, or channel i is currently granted, overrun[i] is set and no second request is queued.
- **Arbiter FSM, states IDLE and GRANT (enum in package):**
  - IDLE: if any pending bit is set, pick the first pending channel after last_grant (wrapping). Set go[sel], clear pending[sel], start the timeout counter and move to GRANT.
  - GRANT: go[sel] stays high.
    - done[sel] sampled high: go clears at that edge, last_grant <= sel, return to IDLE.
    - Counter reaches TIMEOUT-1 without done: go clears, timeout is set, last_grant <= sel, return to IDLE.
  - done on any non-granted channel, or done while in IDLE, is ignored.
  - Dropping enable[sel] during GRANT does not abort the grant.
- busy = (state == GRANT).
- **Flags:** clr_flags clears overrun and timeout. If a set and a clear land in the same cycle, the set wins.

## Timing
- **Reset values:** go=0, busy=0, base_tick=0, overrun=0, timeout=0, all counters 0, state IDLE, last_grant=N_CH-1 (channel 0 has first priority).
- **Reset mid-grant:** go drops asynchronously. No pending request survives reset.
- **First base_tick:** high during the cycle following the (BASE_CYCLES+1)th active edge after reset release.
- **Fire latency:**
  - base_tick high in cycle t: pending is set at the end of t, and go rises in t+1 if the FSM is IDLE.
  - done high in cycle t: go is low from t+1. The FSM is IDLE in t+1, so the next grant starts at t+2 at the earliest.
- At most one go bit is high in any cycle. go is never high together with state IDLE.

## Structure
- Package tick_sched_pkg holds:
  - the state enum typedef (IDLE, GRANT);
  - the N_CH_MAX=8 constant;
  - a round-robin next-index helper function.
- Sub-module tick_gen: base tick generator with clk, rst_n, pause and BASE_CYCLES parameter.
- Channel counters, pending/overrun logic and the arbiter FSM live in tick_scheduler.

## Test plan
Bench parameters: BASE_CYCLES=3, N_CH=4, TIMEOUT=16.
- **Reset:** release rst_n -> all outputs 0; base_tick pulses every 4 clocks; first pulse in cycle 4.
- **Single channel:** period[0]=2, enable=0001, done[0] asserted 1 cycle after go -> go[0] rises every 8 clocks, 1 cycle after every second base_tick, and lasts 2 cycles.
- **Round robin:** all periods=1, enable=1111, done immediate -> grant order 0,1,2,3,0…; never two go bits high; overrun[3] sets, since each fire lands while its request is still pending.
- **Overrun then timeout:** period[1]=1, done[1] never asserted -> overrun[1] sets at the next base tick; go[1] drops after 16 cycles; timeout=1. clr_flags then clears both; a coincident set keeps the flag at 1.
- **Reset mid-grant:** rst_n low while go[2]=1 -> go=0 immediately; after release, channel 0 is served first.
- **Pause and zero period:** pause high for 20 cycles -> no base_tick and counters frozen, and a go already open stays open until done. period=0 with enable=1 -> that channel never fires.
